// File: rtl/mwc_pkg.sv
// Shared types for the data-memory write checker: FSM state and failure cause encodings.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mwc_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BAD_ADDR = 2'd1,
    BAD_DATA = 2'd2,
    TIMEOUT  = 2'd3
  } mwc_fail_e;

endpackage

// File: rtl/mwc_addr_match.sv
// N_IGN-way compare of a write address against the enabled scratch-address slots.
module mwc_addr_match #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned N_IGN  = 2
) (
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [N_IGN*ADDR_W-1:0] i_ign_addr,
  input  logic [N_IGN-1:0]        i_ign_valid,
  output logic                    o_hit_c
);

  always_comb begin
    o_hit_c = 1'b0;
    for (int unsigned j = 0; j < N_IGN; j++) begin
      if (i_ign_valid[j] && (i_ign_addr[j*ADDR_W +: ADDR_W] == i_addr)) begin
        o_hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the CPU data-memory write port: ordered expected writes, scratch tolerance, timeout.
// Optional capture of the offending write (err_addr/err_data) when MWC_ERR_CAPTURE_EN is defined.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_EXP   = 4,
  parameter int unsigned N_IGN   = 2,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear,
  input  logic [N_EXP*ADDR_W-1:0]      exp_addr,
  input  logic [N_EXP*DATA_W-1:0]      exp_data,
  input  logic [N_IGN*ADDR_W-1:0]      ign_addr,
  input  logic [N_IGN-1:0]             ign_valid,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            DataAdr,
  input  logic [DATA_W-1:0]            WriteData,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [$clog2(N_EXP+1)-1:0]   exp_idx,
  output logic [$clog2(TIMEOUT+1)-1:0] cycle_cnt
`ifdef MWC_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [DATA_W-1:0]            err_data
`endif
);

  localparam int unsigned IDX_W = $clog2(N_EXP + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mwc_state_e        r_state;
  mwc_state_e        w_state_nxt;
  mwc_fail_e         r_fail_code;
  mwc_fail_e         w_code_nxt;
  logic [IDX_W-1:0]  r_exp_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_cur_data;
  logic              w_ign_hit;

  mwc_addr_match #(
    .ADDR_W (ADDR_W),
    .N_IGN  (N_IGN)
  ) u_ign_match (
    .i_addr      (DataAdr),
    .i_ign_addr  (ign_addr),
    .i_ign_valid (ign_valid),
    .o_hit_c     (w_ign_hit)
  );

  // Select the table entry for the next expected write.
  always_comb begin
    w_cur_addr = '0;
    w_cur_data = '0;
    for (int unsigned i = 0; i < N_EXP; i++) begin
      if (r_exp_idx == IDX_W'(i)) begin
        w_cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
        w_cur_data = exp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and verdict logic; a write verdict on the timeout edge wins over TIMEOUT.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_fail_code;
    w_idx_nxt   = r_exp_idx;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = IDLE;
      w_code_nxt  = NONE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = RUN;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (r_cnt != CNT_W'(TIMEOUT)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (MemWrite) begin
            if (DataAdr == w_cur_addr) begin
              if (WriteData == w_cur_data) begin
                w_idx_nxt = r_exp_idx + IDX_W'(1);
                if (w_idx_nxt == IDX_W'(N_EXP)) begin
                  w_state_nxt = PASS;
                end
              end else begin
                w_state_nxt = FAIL;
                w_code_nxt  = BAD_DATA;
              end
            end else if (!w_ign_hit) begin
              w_state_nxt = FAIL;
              w_code_nxt  = BAD_ADDR;
            end
          end
          if ((w_state_nxt == RUN) && (w_cnt_nxt == CNT_W'(TIMEOUT))) begin
            w_state_nxt = FAIL;
            w_code_nxt  = mwc_pkg::TIMEOUT;
          end
        end
        PASS:    w_state_nxt = PASS;
        FAIL:    w_state_nxt = FAIL;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fail_code <= NONE;
      r_exp_idx   <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_code <= w_code_nxt;
      r_exp_idx   <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_done      <= (w_state_nxt == PASS) || (w_state_nxt == FAIL);
      r_pass      <= (w_state_nxt == PASS);
      r_fail      <= (w_state_nxt == FAIL);
    end
  end

`ifdef MWC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_data;

  // Capture the write that caused an address/data failure; timeouts leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if (clear) begin
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if ((r_state == RUN) && (w_state_nxt == FAIL) && (w_code_nxt != mwc_pkg::TIMEOUT)) begin
      r_err_addr <= DataAdr;
      r_err_data <= WriteData;
    end
  end

  assign err_addr = r_err_addr;
  assign err_data = r_err_data;
`endif

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign exp_idx   = r_exp_idx;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized runs against a behavioural model.
module tb_mem_write_checker;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NE = 2;
  localparam int unsigned NI = 1;
  localparam int unsigned TO = 50;
  localparam int unsigned IW = $clog2(NE + 1);
  localparam int unsigned CW = $clog2(TO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] data_adr = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] t_ea [NE];
  logic [DW-1:0] t_ed [NE];
  logic [AW-1:0] t_ig [NI];
  logic [NI-1:0] ign_valid = '0;
  logic [NE*AW-1:0] exp_addr;
  logic [NE*DW-1:0] exp_data;
  logic [NI*AW-1:0] ign_addr;

  logic          done, pass, fail;
  logic [1:0]    fail_code;
  logic [IW-1:0] exp_idx;
  logic [CW-1:0] cycle_cnt;
`ifdef MWC_ERR_CAPTURE_EN
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
`endif

  int checks = 0;
  int errors = 0;

  always_comb begin
    for (int i = 0; i < NE; i++) begin
      exp_addr[i*AW +: AW] = t_ea[i];
      exp_data[i*DW +: DW] = t_ed[i];
    end
    for (int j = 0; j < NI; j++) begin
      ign_addr[j*AW +: AW] = t_ig[j];
    end
  end

  mem_write_checker #(
    .ADDR_W(AW), .DATA_W(DW), .N_EXP(NE), .N_IGN(NI), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .clear(clear),
    .exp_addr(exp_addr), .exp_data(exp_data), .ign_addr(ign_addr), .ign_valid(ign_valid),
    .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
    .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
    .exp_idx(exp_idx), .cycle_cnt(cycle_cnt)
`ifdef MWC_ERR_CAPTURE_EN
    , .err_addr(err_addr), .err_data(err_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: whole-run verdict tracking straight from the write-checking rules.
  bit             m_run = 0, m_pass = 0, m_fail = 0;
  int             m_idx = 0, m_cnt = 0, m_code = 0;
  logic [AW-1:0]  m_eaddr = '0;
  logic [DW-1:0]  m_edata = '0;

  task automatic m_reset();
    m_run = 0; m_pass = 0; m_fail = 0;
    m_idx = 0; m_cnt = 0; m_code = 0;
    m_eaddr = '0; m_edata = '0;
  endtask

  task automatic m_fail_with(input int code, input bit capture);
    m_run = 0; m_fail = 1; m_code = code;
    if (capture) begin
      m_eaddr = data_adr;
      m_edata = write_data;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit scratch;
    if (!rst_n || clear) begin
      m_reset();
    end else if (!m_run && !m_pass && !m_fail) begin
      if (start) begin
        m_run = 1; m_idx = 0; m_cnt = 0;
      end
    end else if (m_run) begin
      m_cnt = (m_cnt + 1 > TO) ? TO : m_cnt + 1;
      if (mem_write) begin
        scratch = 0;
        for (int j = 0; j < NI; j++) if (ign_valid[j] && data_adr == t_ig[j]) scratch = 1;
        if (data_adr == t_ea[m_idx]) begin
          if (write_data == t_ed[m_idx]) begin
            m_idx++;
            if (m_idx == NE) begin m_run = 0; m_pass = 1; end
          end else m_fail_with(2, 1);
        end else if (!scratch) m_fail_with(1, 1);
      end
      if (m_run && m_cnt == TO) m_fail_with(3, 0);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("done", done, m_pass | m_fail);
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("pass_fail_excl", pass & fail, 0);
    chk("fail_code", fail_code, m_code);
    chk("exp_idx", exp_idx, m_idx);
    chk("cycle_cnt", cycle_cnt, m_cnt);
`ifdef MWC_ERR_CAPTURE_EN
    chk("err_addr", err_addr, m_eaddr);
    chk("err_data", err_data, m_edata);
`endif
  end

  task automatic do_write(input int a, input int d);
    mem_write = 1'b1; data_adr = AW'(a); write_data = DW'(d);
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic set_default_tables();
    t_ea[0] = 32'd100; t_ed[0] = 32'd7;
    t_ea[1] = 32'd104; t_ed[1] = 32'd9;
    t_ig[0] = 32'd96;  ign_valid = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    set_default_tables();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_done", done, 0);
    chk("rst_idx", exp_idx, 0);
    chk("rst_cnt", cycle_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scratch write, then both expected writes in order.
    do_start();
    do_write(96, 3);   chk("t1_idx0", exp_idx, 0);
    do_write(100, 7);  chk("t1_idx1", exp_idx, 1); chk("t1_nopass", pass, 0);
    do_write(104, 9);  chk("t1_idx2", exp_idx, 2); chk("t1_pass", pass, 1);
    chk("t1_code", fail_code, 0);

    // Clear out of PASS; writes and start+clear in IDLE must not act.
    do_clear();        chk("t6_done", done, 0); chk("t6_idx", exp_idx, 0);
    do_write(200, 7);  chk("t6_nofail", fail, 0);
    start = 1'b1; clear = 1'b1; @(negedge clk); start = 1'b0; clear = 1'b0;
    do_write(200, 7);  chk("t6_idle_fail", fail, 0); chk("t6_idle_cnt", cycle_cnt, 0);

    // Data mismatch on the second expected write.
    do_start();
    do_write(100, 7);
    do_write(104, 8);  chk("t2_fail", fail, 1); chk("t2_code", fail_code, 2);
`ifdef MWC_ERR_CAPTURE_EN
    chk("t2_err_addr", err_addr, 104); chk("t2_err_data", err_data, 8);
`endif
    do_clear();

    // Unknown address; verdict is sticky.
    do_start();
    do_write(200, 7);  chk("t3_code", fail_code, 1);
    do_write(100, 7);
    do_write(104, 9);  chk("t3_sticky", fail_code, 1); chk("t3_idx", exp_idx, 0);
    do_clear();

    // Timeout, then a completing write on the timeout edge.
    do_start();
    repeat (49) @(negedge clk);
    chk("t4_cnt49", cycle_cnt, 49); chk("t4_nofail", fail, 0);
    @(negedge clk);
    chk("t4_fail", fail, 1); chk("t4_code", fail_code, 3); chk("t4_cnt50", cycle_cnt, 50);
    do_clear();
    do_start();
    do_write(100, 7);
    repeat (48) @(negedge clk);
    chk("t4b_cnt49", cycle_cnt, 49);
    do_write(104, 9);
    chk("t4b_pass", pass, 1); chk("t4b_fail", fail, 0); chk("t4b_cnt", cycle_cnt, 50);
    do_clear();

    // Async reset mid-run, then restart.
    do_start();
    do_write(100, 7);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_idx", exp_idx, 0); chk("t5_done", done, 0); chk("t5_cnt", cycle_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    do_write(100, 7);  chk("t5_restart_idx", exp_idx, 1);
    do_clear();

    // Randomized runs with small address pools so scratch/expected collisions occur.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NE; i++) begin
        t_ea[i] = AW'(96 + 4 * $urandom_range(0, 4));
        t_ed[i] = DW'($urandom_range(0, 3));
      end
      t_ig[0]   = AW'(96 + 4 * $urandom_range(0, 4));
      ign_valid = 1'($urandom_range(0, 1));
      do_start();
      for (int c = 0; c < 70 && m_run; c++) begin
        int k;
        k = $urandom_range(0, 11);
        if (k <= 3) begin
          mem_write = 1'b1; data_adr = t_ea[m_idx]; write_data = t_ed[m_idx];
        end else if (k == 4) begin
          mem_write = 1'b1; data_adr = t_ea[m_idx]; write_data = t_ed[m_idx] ^ DW'(1);
        end else if (k == 5) begin
          mem_write = 1'b1; data_adr = t_ig[0]; write_data = DW'($urandom);
        end else if (k == 6) begin
          mem_write = 1'b1; data_adr = AW'(96 + 4 * $urandom_range(0, 5)); write_data = DW'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 99) == 0) clear = 1'b1;
        @(negedge clk);
        mem_write = 1'b0; clear = 1'b0;
        if (!m_run && !m_pass && !m_fail) break;
      end
      if (r % 5 == 4) repeat (TO + 2) @(negedge clk);
      repeat (2) @(negedge clk);
      do_clear();
    end

    // One run left idle to reach timeout under random tables.
    do_start();
    repeat (TO + 3) @(negedge clk);
    chk("rand_timeout", fail_code, 3);
    do_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
